// File: rtl/lsu_mem_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : lsu_mem_port
//  Function : Load/store initiator for a 32-bit byte-enabled data memory.
//             Accepts one request at a time, issues a single memory access
//             with lane-aligned byte enables and write data, extracts and
//             extends load data, and returns a response (with fault flag).
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_port #(
   parameter int ADDR_W            = 32,
   parameter bit FAULT_ON_MISALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   // request channel
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   // response channel
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   // memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   // RV32I width codes
   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   // latched request attributes needed after the handshake
   logic              r_store;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;

   // registered memory-port outputs
   logic              r_mem_req;
   logic              r_mem_we;
   logic [3:0]        r_mem_be;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wd;

   // registered response payload
   logic [31:0]       r_resp_rdata;
   logic              r_resp_fault;

   // request decode
   logic              w_accept;
   logic              w_issue;
   logic              w_is_half;
   logic              w_is_word;
   logic              w_f3_legal;
   logic              w_misalign;
   logic              w_fault;
   logic [1:0]        w_off;
   logic [3:0]        w_be;
   logic [31:0]       w_wd;

   // load extraction
   logic [31:0]       w_shift;
   logic [31:0]       w_ext;

   assign w_accept  = (r_state == ST_IDLE) && req_valid;
   assign w_issue   = w_accept && !w_fault;
   assign w_is_half = (req_funct3[1:0] == 2'b01);
   assign w_is_word = (req_funct3[1:0] == 2'b10);

   // Legal width codes; unsigned variants exist only for loads
   always_comb begin
      w_f3_legal = 1'b0;
      case (req_funct3)
         c_F3_B, c_F3_H, c_F3_W: w_f3_legal = 1'b1;
         c_F3_BU, c_F3_HU:       w_f3_legal = !req_store;
         default:                w_f3_legal = 1'b0;
      endcase
   end

   assign w_misalign = (w_is_half && req_addr[0]) ||
                       (w_is_word && (req_addr[1:0] != 2'b00));
   assign w_fault    = !w_f3_legal || (FAULT_ON_MISALIGN && w_misalign);

   // Effective lane offset: misaligned low bits are dropped when not faulting
   always_comb begin
      w_off = req_addr[1:0];
      if (w_is_word) begin
         w_off = 2'b00;
      end else if (w_is_half) begin
         w_off = {req_addr[1], 1'b0};
      end
   end

   // Byte enables positioned on the addressed lanes
   always_comb begin
      w_be = 4'b0001 << w_off;
      if (w_is_word) begin
         w_be = 4'b1111;
      end else if (w_is_half) begin
         w_be = 4'b0011 << w_off;
      end
   end

   assign w_wd = req_wdata << {w_off, 3'b000};

   // Load data: bring the addressed lanes down to bit 0 and extend
   assign w_shift = mem_rd >> {r_off, 3'b000};

   // Sign or zero extension selected by the latched width code
   always_comb begin
      w_ext = w_shift;
      case (r_funct3)
         c_F3_B:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         c_F3_BU: w_ext = {24'h000000, w_shift[7:0]};
         c_F3_H:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         c_F3_HU: w_ext = {16'h0000, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

   // State register; reset wins over every transition
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_nxt = w_fault ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS:  w_state_nxt = r_store ? ST_RESP : ST_CAPTURE;
         ST_CAPTURE: w_state_nxt = ST_RESP;
         ST_RESP: begin
            if (resp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Latch request attributes at the request handshake
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_store  <= 1'b0;
         r_funct3 <= 3'b000;
         r_off    <= 2'b00;
      end else if (w_accept) begin
         r_store  <= req_store;
         r_funct3 <= req_funct3;
         r_off    <= w_off;
      end
   end

   // Memory strobe and payload: loaded at the handshake so they are valid
   // exactly during the ACCESS cycle, and cleared on every other cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_be   <= 4'b0000;
         r_mem_addr <= '0;
         r_mem_wd   <= 32'h0;
      end else begin
         r_mem_req  <= w_issue;
         r_mem_we   <= w_issue && req_store;
         r_mem_be   <= w_issue ? w_be : 4'b0000;
         r_mem_addr <= w_issue ? {req_addr[ADDR_W-1:2], 2'b00} : '0;
         r_mem_wd   <= w_issue ? w_wd : 32'h0;
      end
   end

   // Response payload: written on entry to RESP, held while RESP waits
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_resp_rdata <= 32'h0;
         r_resp_fault <= 1'b0;
      end else begin
         if (w_accept && w_fault) begin
            r_resp_rdata <= 32'h0;
            r_resp_fault <= 1'b1;
         end else if ((r_state == ST_ACCESS) && r_store) begin
            r_resp_rdata <= 32'h0;
            r_resp_fault <= 1'b0;
         end else if (r_state == ST_CAPTURE) begin
            r_resp_rdata <= w_ext;
            r_resp_fault <= 1'b0;
         end
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_fault = r_resp_fault;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_be     = r_mem_be;
   assign mem_addr   = r_mem_addr;
   assign mem_wd     = r_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lsu_mem_port
//  Function : Self-checking bench for lsu_mem_port. Instance 0 faults on
//             misalignment, instance 1 forces low address bits to zero.
//             Each instance has its own registered-read memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_port;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic [1:0]        resp_valid;
   logic              resp_ready;
   logic [1:0][31:0]  resp_rdata;
   logic [1:0]        resp_fault;
   logic [1:0]        mem_req;
   logic [1:0]        mem_we;
   logic [1:0][3:0]   mem_be;
   logic [1:0][31:0]  mem_addr;
   logic [1:0][31:0]  mem_wd;
   logic [1:0][31:0]  mem_rd;

   logic [31:0]       smem [2][64];
   logic [7:0]        refm [2][256];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDR_W(32), .FAULT_ON_MISALIGN(1'b1)) u_dut0 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
      .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]),
      .mem_addr(mem_addr[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0])
   );

   lsu_mem_port #(.ADDR_W(32), .FAULT_ON_MISALIGN(1'b0)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
      .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]),
      .mem_addr(mem_addr[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1])
   );

   // Data memories: byte-masked writes, read data registered one cycle
   always @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (!reset_n) begin
            for (int w = 0; w < 64; w++) smem[s][w] <= 32'h0;
            smem[s][4] <= 32'h8899AABB;
            mem_rd[s]  <= 32'h0;
         end else if (mem_req[s]) begin
            if (mem_we[s]) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be[s][b]) smem[s][mem_addr[s][7:2]][8*b +: 8] <= mem_wd[s][8*b +: 8];
            end else begin
               mem_rd[s] <= smem[s][mem_addr[s][7:2]];
            end
         end
      end
   end

   // Reference memory as plain bytes, matching the memory's reset image
   task automatic ref_init();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 256; i++) refm[s][i] = 8'h00;
         refm[s][16] = 8'hBB; refm[s][17] = 8'hAA;
         refm[s][18] = 8'h99; refm[s][19] = 8'h88;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One transaction on instance sel, checked against the byte-level model.
   // hold = cycles of response back-pressure; early = keep req_valid high
   // across the response handshake to show it is not taken that cycle.
   task automatic run(input int sel, input bit st, input bit [2:0] f3,
                      input bit [31:0] a, input bit [31:0] wd, input int hold,
                      input bit early, output logic [31:0] rd_o, output logic flt_o);
      int          size, off, lat, nreq;
      bit          legal, efault;
      bit [31:0]   ea;
      logic [31:0] erd;
      logic [3:0]  ebe;
      logic        we_s;
      logic [3:0]  be_s;
      logic [31:0] ma_s, wd_s;

      size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
      efault = !legal || (sel == 0 && (a % size) != 0);
      ea     = a - (a % size);
      off    = int'(ea % 4);
      ebe    = 4'(((32'd1 << size) - 32'd1) << off);
      erd    = 32'h0;
      if (!efault && !st) begin
         for (int i = 0; i < size; i++) erd = erd | (32'(refm[sel][ea + i]) << (8 * i));
         if (!f3[2] && size < 4 && erd[8*size-1]) erd = erd - (32'd1 << (8 * size));
      end

      resp_ready = 1'b0;
      @(negedge clk);
      req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid[sel] = 1'b1;
      chk("req_ready_idle", 32'(req_ready[sel]), 32'd1);
      @(posedge clk);
      #1 req_valid[sel] = 1'b0;

      lat = 0; nreq = 0;
      we_s = 1'b0; be_s = 4'h0; ma_s = 32'h0; wd_s = 32'h0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clk);
         if (mem_req[sel]) begin
            nreq++;
            we_s = mem_we[sel]; be_s = mem_be[sel]; ma_s = mem_addr[sel]; wd_s = mem_wd[sel];
         end
         if (resp_valid[sel]) lat = c;
      end
      if (lat == 0) begin
         chk("resp_timeout", 32'(resp_valid[sel]), 32'd1);
         rd_o = 32'h0; flt_o = 1'b0;
         return;
      end
      rd_o  = resp_rdata[sel];
      flt_o = resp_fault[sel];

      chk("latency", 32'(lat), efault ? 32'd1 : (st ? 32'd2 : 32'd3));
      chk("mem_req_cycles", 32'(nreq), efault ? 32'd0 : 32'd1);
      chk("resp_fault", 32'(flt_o), 32'(efault));
      chk("resp_rdata", rd_o, erd);
      chk("req_ready_busy", 32'(req_ready[sel]), 32'd0);
      if (!efault) begin
         chk("mem_we", 32'(we_s), 32'(st));
         chk("mem_be", 32'(be_s), 32'(ebe));
         chk("mem_addr", ma_s, ea & ~32'd3);
         if (st) chk("mem_wd", wd_s, wd << (8 * off));
      end
      if (!efault && st)
         for (int i = 0; i < size; i++) refm[sel][ea + i] = wd[8*i +: 8];

      if (early) req_valid[sel] = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid[sel]), 32'd1);
         chk("hold_rdata", resp_rdata[sel], erd);
         chk("hold_fault", 32'(resp_fault[sel]), 32'(efault));
         chk("hold_req_ready", 32'(req_ready[sel]), 32'd0);
         chk("hold_mem_req", 32'(mem_req[sel]), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_cleared", 32'(resp_valid[sel]), 32'd0);
      chk("idle_ready", 32'(req_ready[sel]), 32'd1);
      chk("no_same_cycle_accept", 32'(mem_req[sel]), 32'd0);
      req_valid[sel] = 1'b0;
   endtask

   logic [31:0] rd;
   logic        flt;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
      req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      ref_init();
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
         chk("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
         chk("rst_resp_rdata", resp_rdata[s], 32'h0);
         chk("rst_resp_fault", 32'(resp_fault[s]), 32'd0);
         chk("rst_mem_ctl", {27'h0, mem_req[s], mem_we[s], mem_be[s][2:0]}, 32'h0);
         chk("rst_mem_be3", 32'(mem_be[s][3]), 32'd0);
         chk("rst_mem_addr", mem_addr[s], 32'h0);
         chk("rst_mem_wd", mem_wd[s], 32'h0);
      end
      reset_n = 1'b1;

      // Directed loads from the preloaded word 0x8899AABB at 0x10
      run(0, 1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0, rd, flt);
      chk("LB_0x13", rd, 32'hFFFFFF88);
      run(0, 1'b0, 3'b100, 32'h12, 32'h0, 0, 1'b0, rd, flt);
      chk("LBU_0x12", rd, 32'h00000099);
      run(0, 1'b0, 3'b001, 32'h12, 32'h0, 0, 1'b0, rd, flt);
      chk("LH_0x12", rd, 32'hFFFF8899);
      run(0, 1'b0, 3'b101, 32'h10, 32'h0, 0, 1'b0, rd, flt);
      chk("LHU_0x10", rd, 32'h0000AABB);
      run(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, flt);
      chk("LW_0x10", rd, 32'h8899AABB);

      // Byte store into lane 1, then read back the whole word
      run(0, 1'b1, 3'b000, 32'h11, 32'h000000CC, 0, 1'b0, rd, flt);
      chk("SB_rdata", rd, 32'h0);
      run(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, flt);
      chk("LW_after_SB", rd, 32'h8899CCBB);

      // Misaligned accesses: fault on instance 0, forced alignment on 1
      run(0, 1'b0, 3'b010, 32'h12, 32'h0, 0, 1'b0, rd, flt);
      chk("LW_0x12_fault", 32'(flt), 32'd1);
      run(0, 1'b1, 3'b001, 32'h13, 32'h12345678, 0, 1'b0, rd, flt);
      chk("SH_0x13_fault", 32'(flt), 32'd1);
      run(1, 1'b0, 3'b010, 32'h12, 32'h0, 0, 1'b0, rd, flt);
      chk("LW_0x12_aligned", rd, 32'h8899AABB);

      // Illegal width code and load-only code on a store
      run(0, 1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0, rd, flt);
      run(1, 1'b1, 3'b100, 32'h10, 32'h55, 0, 1'b0, rd, flt);

      // Back-pressure for four cycles with a request waiting
      run(0, 1'b0, 3'b010, 32'h10, 32'h0, 4, 1'b1, rd, flt);

      // Reset during the CAPTURE cycle of a load drops it silently
      @(negedge clk);
      req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid[0] = 1'b1;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      chk("rst_test_access", 32'(mem_req[0]), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_req_ready", 32'(req_ready[0]), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("midrst_mem_ctl", {27'h0, mem_req[0], mem_we[0], mem_be[0][2:0]}, 32'h0);
      chk("midrst_mem_be3", 32'(mem_be[0][3]), 32'd0);
      chk("midrst_mem_addr", mem_addr[0], 32'h0);
      chk("midrst_mem_wd", mem_wd[0], 32'h0);
      reset_n = 1'b1;
      ref_init();
      resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_no_resp", 32'(resp_valid[0]), 32'd0);
      end
      resp_ready = 1'b0;

      // Randomised traffic on both instances against the byte model
      for (int n = 0; n < 80; n++) begin
         run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 2)), 1'b0, rd, flt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that drives the 32-bit byte-enabled data memory on behalf of the core.
- Accepts one load/store request at a time from the execute/memory stage over a valid/ready handshake.
- Generates the word address, byte enables and lane-shifted write data, and issues one memory access.
- For loads, captures the registered read data and extracts/sign- or zero-extends it. Returns a response, including a misalignment fault, over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of the request and memory address.
- FAULT_ON_MISALIGN, 1: 1 = a misaligned half/word access returns a fault and touches no memory; 0 = the offending low address bits are forced to zero and the access proceeds.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  misaligned access or illegal funct3.
- mem_req  out  1  memory access strobe; asserted for exactly one cycle per access.
- mem_we  out  1  write enable; only high when mem_req is high.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  byte address with bits [1:0] = 0.
- mem_wd  out  32  lane-aligned write data.
- mem_rd  in  32  read data; valid the cycle after a mem_req with mem_we = 0.

Behaviour:
- Reset values: state IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_fault = 0; mem_req = 0; mem_we = 0; mem_be = 0; mem_addr = 0; mem_wd = 0.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready = 1. When req_valid is high, latch store, funct3, addr and wdata.
  - Fault condition: illegal funct3 (011, 11x, or a load-only code on a store), or (FAULT_ON_MISALIGN = 1 and (H/HU with addr[0] = 1, or W with addr[1:0] != 0)).
  - On fault: go to RESP with resp_fault = 1.
  - Otherwise: go to ACCESS.
- ACCESS, one cycle: mem_req = 1; mem_we = latched store; mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - mem_be = 0001 << off (B), 0011 << off (H), 1111 (W), where off = addr[1:0].
  - mem_wd = wdata << (8*off).
  - Store goes to RESP. Load goes to CAPTURE.
  - All mem_* outputs are registered and return to 0 after this cycle.
- CAPTURE: shift mem_rd right by 8*off, then:
  - B: sign-extend bit 7.
  - BU: zero-extend [7:0].
  - H: sign-extend bit 15.
  - HU: zero-extend [15:0].
  - W: pass through.
  - Register the result into resp_rdata and go to RESP.
- RESP: resp_valid = 1; resp_rdata and resp_fault are stable while resp_ready is low. When resp_ready is high: clear resp_valid and go to IDLE. No request is accepted in that same cycle.
- Latency from the request handshake edge to resp_valid high: load 3 cycles, store 2 cycles, fault 1 cycle. Throughput is one request per (latency + 1) cycles minimum.
- Only one request is outstanding. req_ready is low in every state except IDLE.
- Reset has priority over all transitions.
  - Reset asserted mid-operation returns the FSM to IDLE and drops the pending request; no response is produced.
  - A store whose ACCESS cycle coincides with the reset edge may still be committed by memory.
- The same resp_ready/req_valid behaviour applies whether or not the consumer is back-pressuring.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB addr 0x13 → mem_be 1000, mem_addr 0x10, resp_rdata 0xFFFFFF88 three cycles after the request handshake. LBU 0x12 → 0x00000099.
- LH 0x12 → resp_rdata 0xFFFF8899. LHU 0x10 → 0x0000AABB. LW 0x10 → 0x8899AABB, fault 0.
- SB addr 0x11, wdata 0x000000CC → one-cycle mem_req with mem_we 1, mem_be 0010, mem_wd 0x0000CC00; resp_valid two cycles after the handshake. Then LW 0x10 → 0x8899CCBB.
- LW 0x12 and SH 0x13 with FAULT_ON_MISALIGN = 1 → resp_fault 1, resp_rdata 0, one-cycle latency, mem_req never asserted.
- Same LW 0x12 with FAULT_ON_MISALIGN = 0 → mem_addr 0x10, mem_be 1111, resp_rdata 0x8899AABB, fault 0.
- resp_ready held low 4 cycles during a load → resp_valid and resp_rdata stable, req_ready 0 throughout. A new request is accepted only the cycle after the response handshake.
- reset_n driven low in the CAPTURE cycle of a load → next cycle IDLE, req_ready 1, resp_valid 0, all mem_* outputs 0, no stale response.
